// File: rtl/lvds_send_framer.sv
// lvds_send_framer: transmit-side framer ahead of the 8b/10b encoder.
// Emits a K28.5 training burst after reset or train_req, then wraps source
// bytes into frames: SOF_K, payload, mod-256 checksum, EOF_K, with commas
// between frames and FILL_K whenever the source stalls inside a frame.
//
// Handshake: a byte transfers on a rising clk edge where tx_valid and
// tx_ready are both high; tx_ready depends only on state, train_req and rst,
// never on tx_valid, and tx_data/tx_last are ignored when no transfer occurs.
module lvds_send_framer #(
    parameter int unsigned TRAIN_LEN = 256,
    parameter int unsigned IDLE_GAP  = 4,
    parameter logic [7:0]  COMMA     = 8'hBC,
    parameter logic [7:0]  SOF_K     = 8'hFB,
    parameter logic [7:0]  EOF_K     = 8'hFD,
    parameter logic [7:0]  FILL_K    = 8'h1C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        train_req,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic [7:0]  enc_data,
    output logic        enc_k,
    output logic        link_up,
    output logic [15:0] frame_cnt,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_TRAIN   = 3'd0,
        S_IDLE    = 3'd1,
        S_SOF     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_EOF     = 3'd5
    } state_t;

    // One counter serves both the training length and the idle gap.
    localparam int unsigned CNT_MAX = (TRAIN_LEN > IDLE_GAP) ? TRAIN_LEN : IDLE_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_MIN    = CNT_W'(IDLE_GAP);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [7:0]       csum, csum_nx;
    logic [7:0]       sym_data;
    logic             sym_k;
    logic             frame_done;
    logic             hs;

    assign tx_ready  = (state == S_PAYLOAD) & ~train_req & ~rst;
    assign hs        = tx_valid & tx_ready;
    assign dbg_state = state;

    // Next state, counter, checksum and the symbol to register this cycle.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        csum_nx    = csum;
        sym_data   = COMMA;
        sym_k      = 1'b1;
        frame_done = 1'b0;
        case (state)
            S_TRAIN: begin
                if (cnt == TRAIN_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if ((cnt >= GAP_MIN) && tx_valid) begin
                    state_nx = S_SOF;
                end else if (cnt < GAP_MIN) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_SOF: begin
                sym_data = SOF_K;
                csum_nx  = 8'h00;
                state_nx = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (hs) begin
                    sym_data = tx_data;
                    sym_k    = 1'b0;
                    csum_nx  = csum + tx_data;
                    if (tx_last) begin
                        state_nx = S_CSUM;
                    end
                end else begin
                    sym_data = FILL_K;
                end
            end
            S_CSUM: begin
                sym_data = csum;
                sym_k    = 1'b0;
                state_nx = S_EOF;
            end
            S_EOF: begin
                sym_data   = EOF_K;
                frame_done = 1'b1;
                cnt_nx     = '0;
                state_nx   = S_IDLE;
            end
            default: begin
                state_nx = S_TRAIN;
                cnt_nx   = '0;
            end
        endcase
        // Retraining aborts any frame: no checksum, no EOF, no count.
        if (train_req) begin
            state_nx   = S_TRAIN;
            cnt_nx     = '0;
            csum_nx    = 8'h00;
            sym_data   = COMMA;
            sym_k      = 1'b1;
            frame_done = 1'b0;
        end
    end

    // State register plus registered symbol, link and frame counter outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_TRAIN;
            cnt       <= '0;
            csum      <= 8'h00;
            enc_data  <= COMMA;
            enc_k     <= 1'b1;
            link_up   <= 1'b0;
            frame_cnt <= 16'h0000;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            csum     <= csum_nx;
            enc_data <= sym_data;
            enc_k    <= sym_k;
            link_up  <= (state_nx != S_TRAIN);
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_lvds_send_framer.sv
// Directed bench for lvds_send_framer with TRAIN_LEN=16, IDLE_GAP=4.
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_lvds_send_framer;

    localparam logic [7:0] BC = 8'hBC;
    localparam logic [7:0] FB = 8'hFB;
    localparam logic [7:0] FD = 8'hFD;
    localparam logic [7:0] FC = 8'h1C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        train_req = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_last = 1'b0;
    logic        tx_ready;
    logic [7:0]  enc_data;
    logic        enc_k;
    logic        link_up;
    logic [15:0] frame_cnt;
    logic [2:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    logic [8:0] log_q[$];
    logic [8:0] exp_q[$];
    int         rd_idx = 0;

    lvds_send_framer #(.TRAIN_LEN(16), .IDLE_GAP(4)) dut (
        .clk(clk), .rst(rst), .train_req(train_req),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .enc_data(enc_data), .enc_k(enc_k),
        .link_up(link_up), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) log_q.push_back({enc_k, enc_data});

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_d(input logic [7:0] b); exp_q.push_back({1'b0, b}); endtask
    task automatic exp_k(input logic [7:0] b); exp_q.push_back({1'b1, b}); endtask

    // Present one byte and hold it until the DUT takes it.
    task automatic push_byte(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        tx_last  = last;
        #1;
        while (!tx_ready && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 300) begin
            tests++; fails++;
            $error("FAIL push_timeout: observed no_ready expected ready");
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic stall(input int cycles, input logic last);
        tx_valid = 1'b0;
        tx_last  = last;
        repeat (cycles) @(negedge clk);
        tx_last  = 1'b0;
    endtask

    // Find the next SOF in the symbol log, check the comma run before it,
    // then check the symbols after it against exp_q.
    task automatic check_frame(input string tag, input bit exact_gap, input int gap_exp);
        int run, waitc;
        bit found;
        run = 0; waitc = 0; found = 0;
        while (!found && waitc < 400) begin
            if (rd_idx < log_q.size()) begin
                if (log_q[rd_idx] == {1'b1, FB}) found = 1;
                else if (log_q[rd_idx] == {1'b1, BC}) run++;
                else run = 0;
                rd_idx++;
            end else begin
                @(negedge clk); #1; waitc++;
            end
        end
        if (!found) begin
            tests++; fails++;
            $error("FAIL %s_sof: observed none expected FB", tag);
        end else begin
            if (exact_gap) chk({tag, "_gap"}, 16'(run), 16'(gap_exp));
            else           chk({tag, "_gapmin"}, 16'(run >= gap_exp), 16'd1);
            foreach (exp_q[i]) begin
                waitc = 0;
                while (rd_idx >= log_q.size() && waitc < 400) begin
                    @(negedge clk); #1; waitc++;
                end
                if (rd_idx >= log_q.size()) begin
                    tests++; fails++;
                    $error("FAIL %s_sym%0d: observed none expected %0h", tag, i, exp_q[i]);
                end else begin
                    chk($sformatf("%s_sym%0d", tag, i), 16'(log_q[rd_idx]), 16'(exp_q[i]));
                    rd_idx++;
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic count_link_low(input string tag, input int expected);
        int n;
        n = 0;
        while (!link_up && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 16'(n), 16'(expected));
    endtask

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_data", 16'(enc_data), 16'hBC);
        chk("rst_k", 16'(enc_k), 16'd1);
        chk("rst_ready", 16'(tx_ready), 16'd0);
        chk("rst_link", 16'(link_up), 16'd0);
        chk("rst_fcnt", frame_cnt, 16'd0);

        // Training burst: 16 cycles of BC with link down, link up on cycle 17.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("train_sym%0d", i), {7'd0, enc_k, enc_data}, {7'd0, 1'b1, BC});
            chk($sformatf("train_link%0d", i), 16'(link_up), 16'd0);
            chk($sformatf("train_ready%0d", i), 16'(tx_ready), 16'd0);
            @(negedge clk);
        end
        chk("link_up_17", 16'(link_up), 16'd1);
        repeat (3) begin
            @(negedge clk);
            chk("idle_sym", {7'd0, enc_k, enc_data}, {7'd0, 1'b1, BC});
            chk("idle_ready", 16'(tx_ready), 16'd0);
        end

        // Back-to-back frame 11,22,33 -> checksum 66.
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        push_byte(8'h33, 1'b1);
        exp_d(8'h11); exp_d(8'h22); exp_d(8'h33); exp_d(8'h66); exp_k(FD);
        check_frame("f1", 1'b0, 4);
        chk("f1_fcnt", frame_cnt, 16'd1);

        // Two stall cycles (with a stray tx_last) give two fillers.
        push_byte(8'h11, 1'b0);
        stall(2, 1'b1);
        push_byte(8'h22, 1'b0);
        push_byte(8'h33, 1'b1);
        exp_d(8'h11); exp_k(FC); exp_k(FC); exp_d(8'h22); exp_d(8'h33);
        exp_d(8'h66); exp_k(FD);
        check_frame("f2", 1'b1, 5);
        chk("f2_fcnt", frame_cnt, 16'd2);

        // Single-byte frame, then a queued frame with checksum wrap.
        push_byte(8'hFF, 1'b1);
        exp_d(8'hFF); exp_d(8'hFF); exp_k(FD);
        check_frame("f3", 1'b1, 5);
        chk("f3_fcnt", frame_cnt, 16'd3);
        push_byte(8'h80, 1'b0);
        push_byte(8'h90, 1'b1);
        exp_d(8'h80); exp_d(8'h90); exp_d(8'h10); exp_k(FD);
        check_frame("f4", 1'b1, 5);
        chk("f4_fcnt", frame_cnt, 16'd4);

        // Abort with train_req held 3 cycles while a byte is offered.
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        tx_data = 8'h33; tx_valid = 1'b1; train_req = 1'b1;
        #1;
        chk("abort_ready", 16'(tx_ready), 16'd0);
        repeat (3) @(negedge clk);
        train_req = 1'b0; tx_valid = 1'b0;
        chk("abort_link", 16'(link_up), 16'd0);
        count_link_low("abort_link_low", 16);
        chk("abort_fcnt", frame_cnt, 16'd4);
        exp_d(8'h11); exp_d(8'h22);
        for (int i = 0; i < 16; i++) exp_k(BC);
        check_frame("abort", 1'b1, 5);

        // Link recovers and frames flow again.
        push_byte(8'h05, 1'b1);
        exp_d(8'h05); exp_d(8'h05); exp_k(FD);
        check_frame("f5", 1'b0, 4);
        chk("f5_fcnt", frame_cnt, 16'd5);

        // Reset in the middle of a frame.
        push_byte(8'hAA, 1'b0);
        push_byte(8'hBB, 1'b0);
        tx_data = 8'hCC; tx_valid = 1'b1; rst = 1'b1;
        #1;
        chk("rstmid_ready", 16'(tx_ready), 16'd0);
        @(negedge clk);
        rst = 1'b0; tx_valid = 1'b0;
        chk("rstmid_fcnt", frame_cnt, 16'd0);
        chk("rstmid_link", 16'(link_up), 16'd0);
        count_link_low("rstmid_link_low", 16);
        exp_d(8'hAA); exp_d(8'hBB);
        for (int i = 0; i < 16; i++) exp_k(BC);
        check_frame("rstmid", 1'b1, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
